// File: rtl/coef_shift_sequencer_if.sv
// Handshake bundle between the coefficient store, the shift sequencer and the
// tap accumulator. The master modport is the sequencer; slave is its environment.
interface coef_shift_sequencer_if #(
  parameter int COEF_W = 8
);
  localparam int SHIFT_W = $clog2(COEF_W + 1);

  logic [COEF_W-1:0]  polynomial;
  logic               in_data_vld;
  logic               in_rdy;
  logic [SHIFT_W-1:0] shift_amt;
  logic               shift_neg;
  logic               shift_vld;
  logic               shift_rdy;
  logic               shift_last;
  logic [SHIFT_W-1:0] term_idx;
  logic               polynomial_zero;
  logic               busy;

  modport master (
    input  polynomial, in_data_vld, shift_rdy,
    output in_rdy, shift_amt, shift_neg, shift_vld, shift_last,
           term_idx, polynomial_zero, busy
  );

  modport slave (
    output polynomial, in_data_vld, shift_rdy,
    input  in_rdy, shift_amt, shift_neg, shift_vld, shift_last,
           term_idx, polynomial_zero, busy
  );
endinterface

// File: rtl/coef_shift_sequencer.sv
// Decomposes one coefficient per handshake into a stream of shift terms, LSB first.
// Optional macro CSD_EN: recode to canonical signed digits and emit signed terms.
module coef_shift_sequencer #(
  parameter int COEF_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  coef_shift_sequencer_if.master bus
);
  localparam int SHIFT_W = $clog2(COEF_W + 1);
`ifdef CSD_EN
  localparam int MASK_W = COEF_W + 1;
`else
  localparam int MASK_W = COEF_W;
`endif

  typedef enum logic {IDLE, EMIT} state_t;

  state_t             state_q, state_d;
  logic [MASK_W-1:0]  mask_q, mask_d, load_mask;
  logic [SHIFT_W-1:0] idx_q, idx_d, amt;
  logic               vld, last, xfer, accept;
`ifdef CSD_EN
  logic [MASK_W-1:0]  neg_q, neg_d, load_neg;
`endif

  function automatic logic [SHIFT_W-1:0] lowest_set(input logic [MASK_W-1:0] m);
    lowest_set = '0;
    for (int i = MASK_W - 1; i >= 0; i--)
      if (m[i]) lowest_set = SHIFT_W'(i);
  endfunction

`ifdef CSD_EN
  // Returns {negative-digit flags, nonzero-digit flags}; carry is the majority
  // of (x[i], carry, x[i+1]), which guarantees no two adjacent nonzero digits.
  function automatic logic [2*MASK_W-1:0] csd_recode(input logic [COEF_W-1:0] p);
    logic [COEF_W+1:0] x;
    logic              c;
    logic [MASK_W-1:0] nz, ng;
    x  = {2'b00, p};
    c  = 1'b0;
    nz = '0;
    ng = '0;
    for (int i = 0; i < MASK_W; i++) begin
      nz[i] = x[i] ^ c;
      ng[i] = nz[i] & x[i+1];
      c     = (x[i] & c) | (x[i] & x[i+1]) | (c & x[i+1]);
    end
    return {ng, nz};
  endfunction

  assign {load_neg, load_mask} = csd_recode(bus.polynomial);
`else
  assign load_mask = bus.polynomial;
`endif

  // An empty mask in EMIT is the single zero-coefficient beat, hence also last.
  assign vld    = (state_q == EMIT);
  assign amt    = lowest_set(mask_q);
  assign last   = vld && ((mask_q & (mask_q - MASK_W'(1))) == '0);
  assign xfer   = vld && bus.shift_rdy;
  assign accept = bus.in_data_vld && bus.in_rdy;

  assign bus.in_rdy          = !vld || (xfer && last);
  assign bus.shift_vld       = vld;
  assign bus.shift_amt       = amt;
  assign bus.shift_last      = last;
  assign bus.term_idx        = idx_q;
  assign bus.polynomial_zero = vld && (mask_q == '0);
  assign bus.busy            = vld;
`ifdef CSD_EN
  assign bus.shift_neg       = vld && neg_q[amt];
`else
  assign bus.shift_neg       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
`ifdef CSD_EN
    neg_d   = neg_q;
`endif
    if (xfer) begin
      mask_d = mask_q & (mask_q - MASK_W'(1));
      idx_d  = idx_q + SHIFT_W'(1);
      if (last) begin
        state_d = IDLE;
        idx_d   = '0;
      end
    end
    // A coefficient taken on the final beat overrides the return to IDLE.
    if (accept) begin
      state_d = EMIT;
      mask_d  = load_mask;
      idx_d   = '0;
`ifdef CSD_EN
      neg_d   = load_neg;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      idx_q   <= '0;
`ifdef CSD_EN
      neg_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
`ifdef CSD_EN
      neg_q   <= neg_d;
`endif
    end
  end
endmodule

// File: tb/tb_coef_shift_sequencer.sv
// Scoreboard bench for coef_shift_sequencer: accepted coefficients push their
// expected term beats; a separate monitor pops and compares each transferred beat.
module tb_coef_shift_sequencer;
  localparam int COEF_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  coef_shift_sequencer_if #(.COEF_W(COEF_W)) bus ();

  coef_shift_sequencer #(.COEF_W(COEF_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct {
    int amt;
    int neg;
    int last;
    int idx;
    int zero;
  } beat_t;

  beat_t exp_q[$];
  int compared   = 0;
  int mismatched = 0;
  int rdy_mode   = 0;   // 0: always ready, 1: random, 2: held low

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: list of signed power-of-two terms summing to p, lowest first.
  function automatic void model_push(input int p);
    int    pos[$];
    int    sgn[$];
    beat_t b;
`ifdef CSD_EN
    int n = p;
    int k = 0;
    while (n != 0) begin
      if (n % 2 != 0) begin
        int d;
        d = 2 - (n % 4);
        pos.push_back(k);
        sgn.push_back(d < 0 ? 1 : 0);
        n = n - d;
      end
      n = n / 2;
      k++;
    end
`else
    for (int i = 0; i < COEF_W; i++)
      if (((p >> i) & 1) != 0) begin
        pos.push_back(i);
        sgn.push_back(0);
      end
`endif
    if (pos.size() == 0) begin
      b.amt = 0; b.neg = 0; b.last = 1; b.idx = 0; b.zero = 1;
      exp_q.push_back(b);
    end else begin
      for (int i = 0; i < pos.size(); i++) begin
        b.amt  = pos[i];
        b.neg  = sgn[i];
        b.last = (i == pos.size() - 1) ? 1 : 0;
        b.idx  = i;
        b.zero = 0;
        exp_q.push_back(b);
      end
    end
  endfunction

  task automatic send(input int v);
    bit done = 0;
    bus.in_data_vld = 1'b1;
    bus.polynomial  = COEF_W'(v);
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (bus.in_rdy) begin
        done = 1;
        #1 model_push(v);
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", 0, 1);
    bus.in_data_vld = 1'b0;
    bus.polynomial  = COEF_W'($urandom);
  endtask

  // Called just after a posedge (or at time 0).
  task automatic do_reset();
    reset = 1'b1;
    bus.in_data_vld = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_in_rdy",    bus.in_rdy, 1);
    chk("rst_shift_vld", bus.shift_vld, 0);
    chk("rst_last",      bus.shift_last, 0);
    chk("rst_amt",       bus.shift_amt, 0);
    chk("rst_neg",       bus.shift_neg, 0);
    chk("rst_zero",      bus.polynomial_zero, 0);
    chk("rst_busy",      bus.busy, 0);
    chk("rst_term_idx",  bus.term_idx, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done = 0;
    rdy_mode = 0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !bus.shift_vld) done = 1;
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  // Downstream ready driver.
  initial begin
    bus.shift_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.shift_rdy = 1'b1;
        1:       bus.shift_rdy = ($urandom % 3) != 0;
        default: bus.shift_rdy = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pop, handshake rules and stall stability.
  initial begin
    bit stalled = 0;
    int p_amt, p_neg, p_last, p_idx, p_zero;
    beat_t e;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) begin
        stalled = 0;
      end else begin
        chk("vld_vs_pending", bus.shift_vld, (exp_q.size() != 0) ? 1 : 0);
        if (stalled) begin
          chk("stall_vld",  bus.shift_vld, 1);
          chk("stall_amt",  bus.shift_amt, p_amt);
          chk("stall_neg",  bus.shift_neg, p_neg);
          chk("stall_last", bus.shift_last, p_last);
          chk("stall_idx",  bus.term_idx, p_idx);
          chk("stall_zero", bus.polynomial_zero, p_zero);
        end
        if (bus.shift_vld && bus.shift_rdy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("amt",       bus.shift_amt, e.amt);
            chk("neg",       bus.shift_neg, e.neg);
            chk("last",      bus.shift_last, e.last);
            chk("term_idx",  bus.term_idx, e.idx);
            chk("zero",      bus.polynomial_zero, e.zero);
            chk("in_rdy_xfer", bus.in_rdy, e.last);
          end
        end else if (bus.shift_vld) begin
          chk("in_rdy_stall", bus.in_rdy, 0);
        end else begin
          chk("in_rdy_idle", bus.in_rdy, 1);
          chk("busy_idle",   bus.busy, 0);
        end
        stalled = bus.shift_vld && !bus.shift_rdy;
        p_amt  = bus.shift_amt;
        p_neg  = bus.shift_neg;
        p_last = bus.shift_last;
        p_idx  = bus.term_idx;
        p_zero = bus.polynomial_zero;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_data_vld = 1'b0;
    bus.polynomial  = '0;
    do_reset();

    // Three-term coefficient, then a zero coefficient followed back-to-back.
    rdy_mode = 0;
    send(8'h0B);
    send(8'h00);
    send(8'h03);
    drain();

    // Single term held through a three-cycle stall.
    rdy_mode = 2;
    send(8'h80);
    repeat (3) @(negedge clk);
    rdy_mode = 0;
    drain();

    // Continuous in_data_vld: 0x06 must be captured on the last beat of 0x05.
    send(8'h05);
    send(8'h06);
    drain();

    // Reset while the second beat of 0xFF is presented.
    send(8'hFF);
    @(posedge clk);
    #1;
    do_reset();
    send(8'h01);
    drain();

`ifdef CSD_EN
    send(8'h07);
    send(8'hFF);
    drain();
`endif

    // Randomized traffic with random backpressure and gaps.
    rdy_mode = 1;
    for (int n = 0; n < 200; n++) begin
      int v;
      case ($urandom % 8)
        0:       v = 0;
        1:       v = 255;
        default: v = int'($urandom_range(0, 255));
      endcase
      if (($urandom % 4) == 0) begin
        @(posedge clk);
        #1;
      end
      send(v);
      if (n == 120) begin
        @(posedge clk);
        #1;
        do_reset();
        rdy_mode = 1;
      end
    end
    drain();
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
